// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, init FSM states
// and address-bus constants for the init sequencer.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AR    = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  localparam int PRE_ALL_BIT = 10;

  typedef enum logic [3:0] {
    ST_RST,
    ST_IDLE,
    ST_PRE,
    ST_WAIT_RP,
    ST_AR,
    ST_WAIT_RFC,
    ST_MRS,
    ST_WAIT_MRD,
    ST_DONE
  } init_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sdram_delay_timer.sv
// Loadable down-counter; expired_o is high once the
// count has reached zero and stays there until reloaded.
module sdram_delay_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_sequencer.sv
// SDRAM power-up command sequencer: PRECHARGE ALL,
// N x AUTO REFRESH, LOAD MODE, then sticky done.
module sdram_init_sequencer
  import sdram_pkg::*;
#(
  parameter int ADDR_W        = 13,
  parameter int BA_W          = 2,
  parameter int T_RP_CYCLES   = 3,
  parameter int T_RFC_CYCLES  = 7,
  parameter int T_MRD_CYCLES  = 2,
  parameter int REFRESH_COUNT = 2,
  parameter logic [ADDR_W-1:0] MODE_REG = 'h030
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              init_start_i,
  output logic              sdram_ready_o,
  output logic              sdram_init_ack_o,
  output logic              init_done_o,
  output logic              sdram_cke_o,
  output logic              sdram_cs_n_o,
  output logic              sdram_ras_n_o,
  output logic              sdram_cas_n_o,
  output logic              sdram_we_n_o,
  output logic [BA_W-1:0]   sdram_ba_o,
  output logic [ADDR_W-1:0] sdram_addr_o
);

  localparam int T_MAX =
    max3(T_RP_CYCLES, T_RFC_CYCLES, T_MRD_CYCLES);
  localparam int CNT_W = $clog2(T_MAX) + 1;
  localparam int REF_W = $clog2(REFRESH_COUNT + 1) + 1;

  // Wait states last T-1 cycles; timer counts T-2 .. 0.
  localparam logic [CNT_W-1:0] RP_LOAD =
    CNT_W'((T_RP_CYCLES > 1) ? T_RP_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] RFC_LOAD =
    CNT_W'((T_RFC_CYCLES > 1) ? T_RFC_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] MRD_LOAD =
    CNT_W'((T_MRD_CYCLES > 1) ? T_MRD_CYCLES - 2 : 0);
  localparam logic [REF_W-1:0] REF_MAX =
    REF_W'(REFRESH_COUNT);

  init_state_e       state_q, state_d;
  logic              ready_q, ready_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;
  logic              cke_q, cke_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REF_W-1:0]  ref_q, ref_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expired;

  sdram_delay_timer #(.W(CNT_W)) u_timer (
    .clk        (HCLK),
    .rst        (HRESET),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b0;
    ack_d    = 1'b0;
    done_d   = done_q;
    cke_d    = 1'b1;
    cmd_d    = CMD_NOP;
    ba_d     = '0;
    addr_d   = '0;
    ref_d    = ref_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_RST: state_d = ST_IDLE;
      ST_IDLE: begin
        ready_d = 1'b1;
        if (init_start_i) state_d = ST_PRE;
      end
      ST_PRE: begin
        cmd_d               = CMD_PRE;
        addr_d[PRE_ALL_BIT] = 1'b1;
        ack_d               = 1'b1;
        tmr_load            = 1'b1;
        tmr_val             = RP_LOAD;
        state_d = (T_RP_CYCLES > 1) ? ST_WAIT_RP : ST_AR;
      end
      ST_WAIT_RP:
        if (tmr_expired) state_d = ST_AR;
      ST_AR: begin
        cmd_d    = CMD_AR;
        ref_d    = ref_q + 1'b1;
        tmr_load = 1'b1;
        tmr_val  = RFC_LOAD;
        if (T_RFC_CYCLES > 1)
          state_d = ST_WAIT_RFC;
        else
          state_d = (ref_d < REF_MAX) ? ST_AR : ST_MRS;
      end
      ST_WAIT_RFC:
        if (tmr_expired)
          state_d = (ref_q < REF_MAX) ? ST_AR : ST_MRS;
      ST_MRS: begin
        cmd_d    = CMD_MRS;
        addr_d   = MODE_REG;
        tmr_load = 1'b1;
        tmr_val  = MRD_LOAD;
        state_d = (T_MRD_CYCLES > 1) ? ST_WAIT_MRD : ST_DONE;
      end
      ST_WAIT_MRD:
        if (tmr_expired) state_d = ST_DONE;
      ST_DONE: done_d = 1'b1;
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_RST;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      cke_q   <= 1'b0;
      cmd_q   <= CMD_DESEL;
      ba_q    <= '0;
      addr_q  <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      cke_q   <= cke_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      ref_q   <= ref_d;
    end
  end

  assign sdram_ready_o    = ready_q;
  assign sdram_init_ack_o = ack_q;
  assign init_done_o      = done_q;
  assign sdram_cke_o      = cke_q;
  assign {sdram_cs_n_o, sdram_ras_n_o,
          sdram_cas_n_o, sdram_we_n_o} = cmd_q;
  assign sdram_ba_o       = ba_q;
  assign sdram_addr_o     = addr_q;

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Directed bench: default-parameter instance plus an
// all-minimum-timing instance.
module tb_sdram_init_sequencer;

  logic        HCLK = 1'b0;
  logic        rst0, start0, rst1, start1;
  logic        rdy0, ack0, done0, cke0, cs0, ras0, cas0, we0;
  logic [1:0]  ba0;
  logic [12:0] addr0;
  logic        rdy1, ack1, done1, cke1, cs1, ras1, cas1, we1;
  logic [1:0]  ba1;
  logic [12:0] addr1;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  sdram_init_sequencer dut0 (
    .HCLK(HCLK), .HRESET(rst0), .init_start_i(start0),
    .sdram_ready_o(rdy0), .sdram_init_ack_o(ack0),
    .init_done_o(done0), .sdram_cke_o(cke0),
    .sdram_cs_n_o(cs0), .sdram_ras_n_o(ras0),
    .sdram_cas_n_o(cas0), .sdram_we_n_o(we0),
    .sdram_ba_o(ba0), .sdram_addr_o(addr0)
  );

  sdram_init_sequencer #(
    .T_RP_CYCLES(1), .T_RFC_CYCLES(1),
    .T_MRD_CYCLES(1), .REFRESH_COUNT(1)
  ) dut1 (
    .HCLK(HCLK), .HRESET(rst1), .init_start_i(start1),
    .sdram_ready_o(rdy1), .sdram_init_ack_o(ack1),
    .init_done_o(done1), .sdram_cke_o(cke1),
    .sdram_cs_n_o(cs1), .sdram_ras_n_o(ras1),
    .sdram_cas_n_o(cas1), .sdram_we_n_o(we1),
    .sdram_ba_o(ba1), .sdram_addr_o(addr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Cycle n after the sampling edge of init_start_i.
  task automatic run_seq(input string tag);
    logic [3:0]  ecmd;
    logic [12:0] eaddr;
    for (int n = 1; n <= 20; n++) begin
      tick();
      ecmd  = 4'b0111;
      eaddr = 13'h000;
      if (n == 1) begin ecmd = 4'b0010; eaddr = 13'h400; end
      if (n == 4 || n == 11) ecmd = 4'b0001;
      if (n == 18) begin ecmd = 4'b0000; eaddr = 13'h030; end
      chk($sformatf("%s_cmd_c%0d", tag, n),
          {28'd0, cs0, ras0, cas0, we0}, {28'd0, ecmd});
      chk($sformatf("%s_addr_c%0d", tag, n),
          {19'd0, addr0}, {19'd0, eaddr});
      chk($sformatf("%s_ba_c%0d", tag, n), {30'd0, ba0}, 32'd0);
      chk($sformatf("%s_ack_c%0d", tag, n),
          {31'd0, ack0}, {31'd0, (n == 1)});
      chk($sformatf("%s_done_c%0d", tag, n),
          {31'd0, done0}, {31'd0, (n >= 20)});
      chk($sformatf("%s_rdy_c%0d", tag, n), {31'd0, rdy0}, 32'd0);
      chk($sformatf("%s_cke_c%0d", tag, n), {31'd0, cke0}, 32'd1);
    end
  endtask

  initial begin
    rst0 = 1'b1; start0 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0;
    tick(3);
    chk("rst_ready", {31'd0, rdy0}, 32'd0);
    chk("rst_ack",   {31'd0, ack0}, 32'd0);
    chk("rst_done",  {31'd0, done0}, 32'd0);
    chk("rst_cke",   {31'd0, cke0}, 32'd0);
    chk("rst_cmd", {28'd0, cs0, ras0, cas0, we0}, 32'hf);
    chk("rst_addr", {19'd0, addr0}, 32'd0);

    // Release: RST cycle, then IDLE.
    rst0 = 1'b0;
    tick();
    chk("rstst_cke",   {31'd0, cke0}, 32'd1);
    chk("rstst_ready", {31'd0, rdy0}, 32'd0);
    chk("rstst_cmd", {28'd0, cs0, ras0, cas0, we0}, 32'h7);
    tick();
    chk("idle_ready", {31'd0, rdy0}, 32'd1);
    chk("idle_cke",   {31'd0, cke0}, 32'd1);

    // Start held high; this edge samples it.
    start0 = 1'b1;
    tick();
    chk("samp_ack", {31'd0, ack0}, 32'd0);
    chk("samp_cmd", {28'd0, cs0, ras0, cas0, we0}, 32'h7);
    run_seq("seq1");

    // Held high and re-pulsed while DONE: no restart.
    tick(5);
    chk("hold_ack",  {31'd0, ack0}, 32'd0);
    chk("hold_done", {31'd0, done0}, 32'd1);
    start0 = 1'b0;
    tick(2);
    start0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("repulse_ack%0d", i), {31'd0, ack0}, 32'd0);
      chk($sformatf("repulse_cmd%0d", i),
          {28'd0, cs0, ras0, cas0, we0}, 32'h7);
      chk($sformatf("repulse_done%0d", i), {31'd0, done0}, 32'd1);
      chk($sformatf("repulse_rdy%0d", i), {31'd0, rdy0}, 32'd0);
    end

    // Mid-sequence async reset inside WAIT_RFC.
    rst0 = 1'b1; start0 = 1'b0;
    tick();
    rst0 = 1'b0;
    tick(2);
    start0 = 1'b1;
    tick();
    tick(6);
    chk("pre_mid_done", {31'd0, done0}, 32'd0);
    chk("pre_mid_cke",  {31'd0, cke0}, 32'd1);
    #2 rst0 = 1'b1;
    #1;
    chk("mid_cke",  {31'd0, cke0}, 32'd0);
    chk("mid_cmd", {28'd0, cs0, ras0, cas0, we0}, 32'hf);
    chk("mid_done", {31'd0, done0}, 32'd0);
    chk("mid_addr", {19'd0, addr0}, 32'd0);
    tick();
    // Start still high across RST: served at first IDLE edge.
    rst0 = 1'b0;
    tick();
    chk("rerst_ack", {31'd0, ack0}, 32'd0);
    tick();
    chk("rerst_idle_rdy", {31'd0, rdy0}, 32'd1);
    run_seq("seq2");

    // Start low for 50 cycles after reset.
    rst0 = 1'b1; start0 = 1'b0;
    tick();
    rst0 = 1'b0;
    tick(2);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk($sformatf("quiet_rdy%0d", i), {31'd0, rdy0}, 32'd1);
      chk($sformatf("quiet_ack%0d", i), {31'd0, ack0}, 32'd0);
      chk($sformatf("quiet_cmd%0d", i),
          {28'd0, cs0, ras0, cas0, we0}, 32'h7);
    end

    // Minimum timing: PRE, AR, MRS back to back.
    rst1 = 1'b0;
    tick(2);
    chk("min_rdy", {31'd0, rdy1}, 32'd1);
    start1 = 1'b1;
    tick();
    tick();
    chk("min_c1_cmd", {28'd0, cs1, ras1, cas1, we1}, 32'h2);
    chk("min_c1_addr", {19'd0, addr1}, 32'h400);
    chk("min_c1_ack", {31'd0, ack1}, 32'd1);
    tick();
    chk("min_c2_cmd", {28'd0, cs1, ras1, cas1, we1}, 32'h1);
    chk("min_c2_ack", {31'd0, ack1}, 32'd0);
    tick();
    chk("min_c3_cmd", {28'd0, cs1, ras1, cas1, we1}, 32'h0);
    chk("min_c3_addr", {19'd0, addr1}, 32'h030);
    chk("min_c3_ba", {30'd0, ba1}, 32'd0);
    chk("min_c3_done", {31'd0, done1}, 32'd0);
    tick();
    chk("min_c4_done", {31'd0, done1}, 32'd1);
    chk("min_c4_cmd", {28'd0, cs1, ras1, cas1, we1}, 32'h7);
    chk("min_c4_cke", {31'd0, cke1}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
